// File: rtl/quad_position_counter_if.sv
// Decoder-to-counter signal bundle: encoder strobes and config in, position/velocity out.
interface quad_position_counter_if #(
  parameter int COUNT_WIDTH = 32,
  parameter int VEL_WIDTH   = 16
);
  logic                   count_pulse;
  logic                   direction;
  logic                   index;
  logic                   clear_count;
  logic                   index_zero_en;
  logic [COUNT_WIDTH-1:0] position;
  logic [COUNT_WIDTH-1:0] index_position;
  logic                   index_seen;
  logic [VEL_WIDTH-1:0]   velocity;
  logic                   velocity_valid;

  modport master (
    output count_pulse, direction, index, clear_count, index_zero_en,
    input  position, index_position, index_seen, velocity, velocity_valid
  );

  modport slave (
    input  count_pulse, direction, index, clear_count, index_zero_en,
    output position, index_position, index_seen, velocity, velocity_valid
  );
endinterface

// File: rtl/quad_position_counter.sv
// Wrapping signed position counter with index capture/zeroing and a
// fixed-window saturating velocity measurement.
module quad_position_counter #(
  parameter int COUNT_WIDTH = 32,
  parameter int VEL_WIDTH   = 16,
  parameter int VEL_PERIOD  = 50000
) (
  input logic                   clk,
  input logic                   reset,
  quad_position_counter_if.slave bus
);
  localparam int TW = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam logic [TW-1:0]        TIMER_LAST = TW'(VEL_PERIOD - 1);
  localparam logic [VEL_WIDTH-1:0] VMAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VMIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  logic [COUNT_WIDTH-1:0] position_r;
  logic [COUNT_WIDTH-1:0] index_position_r;
  logic [COUNT_WIDTH-1:0] pos_step;
  logic                   index_seen_r;
  logic                   index_q;
  logic                   index_edge;
  logic [TW-1:0]          vel_timer;
  logic [VEL_WIDTH-1:0]   vel_acc;
  logic [VEL_WIDTH-1:0]   acc_next;
  logic [VEL_WIDTH-1:0]   velocity_r;
  logic                   velocity_valid_r;

  assign index_edge = bus.index & ~index_q;

  always_comb begin
    pos_step = position_r;
    if (bus.count_pulse) begin
      if (bus.direction) pos_step = position_r + COUNT_WIDTH'(1);
      else               pos_step = position_r - COUNT_WIDTH'(1);
    end
  end

  // Saturate by refusing to step past the rails; the rail value then holds.
  always_comb begin
    acc_next = vel_acc;
    if (bus.count_pulse) begin
      if (bus.direction) begin
        if (vel_acc != VMAX) acc_next = vel_acc + VEL_WIDTH'(1);
      end else begin
        if (vel_acc != VMIN) acc_next = vel_acc - VEL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q          <= 1'b0;
      position_r       <= '0;
      index_position_r <= '0;
      index_seen_r     <= 1'b0;
    end else begin
      index_q <= bus.index;
      if (bus.clear_count) begin
        position_r   <= '0;
        index_seen_r <= 1'b0;
      end else if (index_edge) begin
        index_position_r <= pos_step;
        position_r       <= bus.index_zero_en ? '0 : pos_step;
        index_seen_r     <= 1'b1;
      end else begin
        position_r <= pos_step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vel_timer        <= '0;
      vel_acc          <= '0;
      velocity_r       <= '0;
      velocity_valid_r <= 1'b0;
    end else begin
      if (vel_timer == TIMER_LAST) begin
        vel_timer        <= '0;
        vel_acc          <= '0;
        velocity_r       <= acc_next;
        velocity_valid_r <= 1'b1;
      end else begin
        vel_timer        <= vel_timer + TW'(1);
        vel_acc          <= acc_next;
        velocity_valid_r <= 1'b0;
      end
    end
  end

  assign bus.position       = position_r;
  assign bus.index_position = index_position_r;
  assign bus.index_seen     = index_seen_r;
  assign bus.velocity       = velocity_r;
  assign bus.velocity_valid = velocity_valid_r;
endmodule

// File: tb/tb_quad_position_counter.sv
// Directed bench: a 32-bit/16-bit counter and an 8-bit/4-bit counter share one stimulus.
module tb_quad_position_counter;
  logic clk;
  logic reset;
  int unsigned applied;
  int unsigned miscompares;

  quad_position_counter_if #(.COUNT_WIDTH(32), .VEL_WIDTH(16)) bus ();
  quad_position_counter_if #(.COUNT_WIDTH(8),  .VEL_WIDTH(4))  bus2 ();

  assign bus2.count_pulse   = bus.count_pulse;
  assign bus2.direction     = bus.direction;
  assign bus2.index         = bus.index;
  assign bus2.clear_count   = bus.clear_count;
  assign bus2.index_zero_en = bus.index_zero_en;

  quad_position_counter #(.COUNT_WIDTH(32), .VEL_WIDTH(16), .VEL_PERIOD(100)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  quad_position_counter #(.COUNT_WIDTH(8), .VEL_WIDTH(4), .VEL_PERIOD(100)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        cp;
    logic        dir;
    logic        idx;
    logic        clr;
    logic        zen;
    logic [31:0] pos;
    logic [31:0] ipos;
    logic        seen;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic cp, input logic dir, input logic idx, input logic clr,
                     input logic zen, input logic [31:0] pos, input logic [31:0] ipos,
                     input logic seen);
    vec_t v;
    v.cp = cp; v.dir = dir; v.idx = idx; v.clr = clr; v.zen = zen;
    v.pos = pos; v.ipos = ipos; v.seen = seen;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic cp, input logic dir);
    bus.count_pulse = cp;
    bus.direction   = dir;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  task automatic velocity_window(input string name, input int npulses, input logic dir,
                                 input logic [31:0] exp16, input logic [31:0] exp4);
    for (int k = 0; k < 100; k++) begin
      drive(k < npulses, dir);
      tick();
      if (k == 0)  check({name, "_valid_low_start"}, 32'(bus.velocity_valid), 32'd0);
      if (k == 98) check({name, "_valid_low_end"}, 32'(bus.velocity_valid), 32'd0);
    end
    drive(1'b0, 1'b0);
    check({name, "_valid"}, 32'(bus.velocity_valid), 32'd1);
    check({name, "_vel16"}, 32'($signed(bus.velocity)), exp16);
    check({name, "_vel4"}, 32'($signed(bus2.velocity)), exp4);
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    reset = 1'b0;
    bus.count_pulse   = 1'b0;
    bus.direction     = 1'b0;
    bus.index         = 1'b0;
    bus.clear_count   = 1'b0;
    bus.index_zero_en = 1'b0;
    #3;
    check("rst_position", bus.position, 32'd0);
    check("rst_index_position", bus.index_position, 32'd0);
    check("rst_index_seen", 32'(bus.index_seen), 32'd0);
    check("rst_velocity", 32'(bus.velocity), 32'd0);
    check("rst_velocity_valid", 32'(bus.velocity_valid), 32'd0);
    check("rst_position8", 32'(bus2.position), 32'd0);
    tick();
    reset = 1'b1;

    // count up/down, then 0 - 1 wraps
    for (int i = 1; i <= 10; i++) add(1, 1, 0, 0, 0, 32'(i), 0, 0);
    add(1, 0, 0, 0, 0, 9, 0, 0);
    add(1, 0, 0, 0, 0, 8, 0, 0);
    add(1, 0, 0, 0, 0, 7, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    add(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    // index held high for 5 clocks captures only once
    for (int i = 1; i <= 25; i++) add(1, 1, 0, 0, 0, 32'(i), 0, 0);
    add(0, 1, 1, 0, 0, 25, 25, 1);
    for (int i = 26; i <= 29; i++) add(1, 1, 1, 0, 0, 32'(i), 25, 1);
    add(0, 0, 0, 0, 0, 29, 25, 1);
    // zero-on-index with a simultaneous up pulse
    add(1, 1, 1, 0, 1, 0, 30, 1);
    add(1, 1, 1, 0, 1, 1, 30, 1);
    add(0, 0, 0, 0, 1, 1, 30, 1);
    // clear beats a same-cycle index edge
    add(0, 0, 1, 1, 0, 0, 30, 0);
    add(0, 0, 1, 0, 0, 0, 30, 0);
    add(0, 0, 0, 0, 0, 0, 30, 0);
    add(1, 1, 1, 0, 0, 1, 1, 1);

    foreach (vecs[i]) begin
      bus.count_pulse   = vecs[i].cp;
      bus.direction     = vecs[i].dir;
      bus.index         = vecs[i].idx;
      bus.clear_count   = vecs[i].clr;
      bus.index_zero_en = vecs[i].zen;
      tick();
      check($sformatf("vec%0d_position", i), bus.position, vecs[i].pos);
      check($sformatf("vec%0d_index_position", i), bus.index_position, vecs[i].ipos);
      check($sformatf("vec%0d_index_seen", i), 32'(bus.index_seen), 32'(vecs[i].seen));
    end
    bus.index       = 1'b0;
    bus.clear_count = 1'b0;
    drive(1'b0, 1'b0);

    // 8-bit counter: 127 + 1 wraps to -128
    bus.clear_count = 1'b1;
    tick();
    bus.clear_count = 1'b0;
    check("clr_position8", 32'(bus2.position), 32'd0);
    for (int i = 0; i < 127; i++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    check("pos8_max", 32'(bus2.position), 32'h7F);
    tick();
    drive(1'b0, 1'b0);
    check("pos8_wrap", 32'(bus2.position), 32'h80);
    check("pos32_no_wrap", bus.position, 32'd128);

    apply_reset();
    velocity_window("win_up40", 40, 1'b1, 32'd40, 32'd7);
    velocity_window("win_dn15", 15, 1'b0, 32'hFFFF_FFF1, 32'hFFFF_FFF8);
    velocity_window("win_idle", 0, 1'b0, 32'd0, 32'd0);
    velocity_window("win_up12", 12, 1'b1, 32'd12, 32'd7);

    // reset mid-window; the window restarts from release
    for (int k = 0; k < 50; k++) begin
      drive(k < 20, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_position", bus.position, 32'd0);
    check("midrst_velocity", 32'(bus.velocity), 32'd0);
    check("midrst_velocity4", 32'(bus2.velocity), 32'd0);
    check("midrst_valid", 32'(bus.velocity_valid), 32'd0);
    tick();
    reset = 1'b1;
    velocity_window("win_after_rst", 5, 1'b1, 32'd5, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
